// File: rtl/ctx_pkg.sv
// Shared types and constants for the context save/restore engine.
// Define CTX_CHECKSUM_EN to append an XOR checksum byte to every frame.
package ctx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SAVE = 3'd1,
        ST_RD   = 3'd2,
        ST_WB   = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] REG_A  = 3'd0;
    localparam logic [IDX_W-1:0] REG_B  = 3'd1;
    localparam logic [IDX_W-1:0] REG_C  = 3'd2;
    localparam logic [IDX_W-1:0] REG_IX = 3'd3;

`ifdef CTX_CHECKSUM_EN
    localparam int unsigned FRAME_STRIDE = 5;
`else
    localparam int unsigned FRAME_STRIDE = 4;
`endif

    // Index of the final byte in a frame (IX, or the checksum byte when enabled)
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_STRIDE - 1);

endpackage

// File: rtl/ctx_frame_ptr.sv
// Up/down count of stacked frames with full/empty flags.
module ctx_frame_ptr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned FP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            dec,
    output logic [FP_W-1:0] count,
    output logic            full_c,
    output logic            empty_c
);

    // Frame count, guarded against wrapping in either direction
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !full_c) begin
            count <= count + FP_W'(1);
        end else if (dec && !empty_c) begin
            count <= count - FP_W'(1);
        end
    end

    assign full_c  = (count == FP_W'(DEPTH));
    assign empty_c = (count == '0);

endmodule

// File: rtl/ctx_save_restore.sv
// Context engine: saves A/B/C/IX to a memory frame stack and restores the
// newest frame through the register file write port.
// Optional build macro: CTX_CHECKSUM_EN (adds checksum byte and CKSUM_ERR).
module ctx_save_restore
    import ctx_pkg::*;
#(
    parameter int unsigned       ADDR_W = 8,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(8'hE0),
    parameter int unsigned       DEPTH  = 4,
    localparam int unsigned      FP_W   = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SAVE_REQ,
    input  logic              RESTORE_REQ,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [FP_W-1:0]   FP,
    input  logic [DATA_W-1:0] OA,
    input  logic [DATA_W-1:0] OB,
    input  logic [DATA_W-1:0] OC,
    input  logic [DATA_W-1:0] OIX,
    output logic              MRWE,
    output logic              WA1,
    output logic              WA0,
    output logic [DATA_W-1:0] RF_IN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    output logic              MEM_RE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_READY
`ifdef CTX_CHECKSUM_EN
    ,
    output logic              CKSUM_ERR
`endif
);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [DATA_W-1:0] csum;
    logic              full_c;
    logic              empty_c;
    logic              fp_inc;
    logic              fp_dec;

    // Frame byte address; wraps within the address width
    function automatic logic [ADDR_W-1:0] frame_addr(input logic [FP_W-1:0] frame,
                                                     input logic [IDX_W-1:0] i);
        return ADDR_W'(32'(BASE) + 32'(frame) * FRAME_STRIDE + 32'(i));
    endfunction

    // Byte to write for frame slot i; slots past IX carry the running checksum
    function automatic logic [DATA_W-1:0] save_byte(input logic [IDX_W-1:0]  i,
                                                    input logic [DATA_W-1:0] acc);
        case (i)
            REG_A:   return OA;
            REG_B:   return OB;
            REG_C:   return OC;
            REG_IX:  return OIX;
            default: return acc;
        endcase
    endfunction

    assign idx_nxt = idx + IDX_W'(1);
    assign fp_inc  = (state == ST_SAVE) && MEM_READY && (idx == LAST_IDX);
`ifdef CTX_CHECKSUM_EN
    assign fp_dec  = (state == ST_RD) && MEM_READY && (idx == LAST_IDX);
`else
    assign fp_dec  = (state == ST_WB) && (idx == LAST_IDX);
`endif

    ctx_frame_ptr #(
        .DEPTH (DEPTH),
        .FP_W  (FP_W)
    ) u_frame_ptr (
        .clk     (CLK),
        .reset   (RESET),
        .inc     (fp_inc),
        .dec     (fp_dec),
        .count   (FP),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Sequencer with registered bus and register-file outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            idx       <= '0;
            csum      <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            MRWE      <= 1'b0;
            WA1       <= 1'b0;
            WA0       <= 1'b0;
            RF_IN     <= '0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_WE    <= 1'b0;
            MEM_RE    <= 1'b0;
`ifdef CTX_CHECKSUM_EN
            CKSUM_ERR <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            MRWE <= 1'b0;
`ifdef CTX_CHECKSUM_EN
            CKSUM_ERR <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    idx  <= '0;
                    csum <= '0;
                    if (SAVE_REQ) begin
                        if (full_c) begin
                            ERR <= 1'b1;
                        end else begin
                            state     <= ST_SAVE;
                            BUSY      <= 1'b1;
                            MEM_WE    <= 1'b1;
                            MEM_ADDR  <= frame_addr(FP, REG_A);
                            MEM_WDATA <= OA;
                        end
                    end else if (RESTORE_REQ) begin
                        if (empty_c) begin
                            ERR <= 1'b1;
                        end else begin
                            state    <= ST_RD;
                            BUSY     <= 1'b1;
                            MEM_RE   <= 1'b1;
                            MEM_ADDR <= frame_addr(FP - FP_W'(1), REG_A);
                        end
                    end
                end
                ST_SAVE: begin
                    if (MEM_READY) begin
                        csum <= csum ^ MEM_WDATA;
                        if (idx == LAST_IDX) begin
                            state     <= ST_FIN;
                            DONE      <= 1'b1;
                            MEM_WE    <= 1'b0;
                            MEM_ADDR  <= '0;
                            MEM_WDATA <= '0;
                        end else begin
                            idx       <= idx_nxt;
                            MEM_ADDR  <= frame_addr(FP, idx_nxt);
                            MEM_WDATA <= save_byte(idx_nxt, csum ^ MEM_WDATA);
                        end
                    end else begin
                        // Live registers are re-sampled while the bus stalls
                        MEM_WDATA <= save_byte(idx, csum);
                    end
                end
                ST_RD: begin
                    if (MEM_READY) begin
                        csum     <= csum ^ MEM_RDATA;
                        MEM_RE   <= 1'b0;
                        MEM_ADDR <= '0;
`ifdef CTX_CHECKSUM_EN
                        if (idx == LAST_IDX) begin
                            state     <= ST_FIN;
                            DONE      <= 1'b1;
                            CKSUM_ERR <= ((csum ^ MEM_RDATA) != '0);
                        end else begin
                            state       <= ST_WB;
                            MRWE        <= 1'b1;
                            {WA1, WA0}  <= idx[1:0];
                            RF_IN       <= MEM_RDATA;
                        end
`else
                        state      <= ST_WB;
                        MRWE       <= 1'b1;
                        {WA1, WA0} <= idx[1:0];
                        RF_IN      <= MEM_RDATA;
`endif
                    end
                end
                ST_WB: begin
                    WA1   <= 1'b0;
                    WA0   <= 1'b0;
                    RF_IN <= '0;
                    if (idx == LAST_IDX) begin
                        state <= ST_FIN;
                        DONE  <= 1'b1;
                    end else begin
                        state    <= ST_RD;
                        idx      <= idx_nxt;
                        MEM_RE   <= 1'b1;
                        MEM_ADDR <= frame_addr(FP - FP_W'(1), idx_nxt);
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    BUSY   <= 1'b0;
                    MEM_WE <= 1'b0;
                    MEM_RE <= 1'b0;
                end
            endcase
        end
    end

endmodule
